// File: rtl/header_uart_sender.sv
// header_uart_sender: streams a 640-bit header as 80 bytes of 8N1,
// then collects the 4-byte nonce reply coming back on rxd.

module header_uart_sender #(
  parameter int CLKS_PER_BIT   = 434,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [639:0] header,
  output logic         txd,
  input  logic         rxd,
  output logic         busy,
  output logic         done,
  output logic         timed_out,
  output logic         frame_err,
  output logic [31:0]  nonce_out,
  output logic [6:0]   bytes_sent
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int OW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_ONE     = TW'(1);
  localparam logic [OW-1:0] TMO_MAX   = OW'(TIMEOUT_CYCLES);
  localparam logic [OW-1:0] TMO_ONE   = OW'(1);
  localparam logic [6:0]    NBYTES    = 7'd80;

  typedef enum logic [3:0] {
    S_IDLE,
    S_TX_START,
    S_TX_DATA,
    S_TX_STOP,
    S_RX_WAIT,
    S_RX_START,
    S_RX_DATA,
    S_RX_STOP,
    S_FINISH
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_nxt;
  logic [2:0]    r_bit;
  logic [2:0]    w_bit_nxt;
  logic [639:0]  r_hdr;
  logic [639:0]  w_hdr_nxt;
  logic [6:0]    r_bytes;
  logic [6:0]    w_bytes_nxt;
  logic [OW-1:0] r_tmo;
  logic [OW-1:0] w_tmo_nxt;
  logic [OW-1:0] w_tmo_inc;
  logic [7:0]    r_rx_byte;
  logic [7:0]    w_rx_byte_nxt;
  logic [1:0]    r_rx_cnt;
  logic [1:0]    w_rx_cnt_nxt;
  logic [31:0]   r_nonce;
  logic [31:0]   w_nonce_nxt;
  logic          r_tout;
  logic          w_tout_nxt;
  logic          r_ferr;
  logic          w_ferr_nxt;
  logic          r_txd;
  logic          w_txd_nxt;
  logic          r_busy;
  logic          r_done;
  logic          r_rx_meta;
  logic          r_rx_sync;
  logic          r_rx_prev;
  logic          w_bit_end;
  logic          w_half_end;
  logic          w_rx_fall;
  logic [7:0]    w_tx_byte;

  assign w_bit_end  = (r_timer == BIT_LAST);
  assign w_half_end = (r_timer == HALF_LAST);
  assign w_rx_fall  = r_rx_prev & ~r_rx_sync;
  assign w_tmo_inc  = (r_tmo >= TMO_MAX) ? r_tmo : r_tmo + TMO_ONE;
  assign w_tx_byte  = w_hdr_nxt[639:632];

  assign txd        = r_txd;
  assign busy       = r_busy;
  assign done       = r_done;
  assign timed_out  = r_tout;
  assign frame_err  = r_ferr;
  assign nonce_out  = r_nonce;
  assign bytes_sent = r_bytes;

  // rxd is asynchronous; r_rx_prev only feeds the falling-edge detect
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rxd;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_bit_nxt     = r_bit;
    w_hdr_nxt     = r_hdr;
    w_bytes_nxt   = r_bytes;
    w_tmo_nxt     = r_tmo;
    w_rx_byte_nxt = r_rx_byte;
    w_rx_cnt_nxt  = r_rx_cnt;
    w_nonce_nxt   = r_nonce;
    w_tout_nxt    = r_tout;
    w_ferr_nxt    = r_ferr;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_hdr_nxt   = header;
          w_nonce_nxt = '0;
          w_tout_nxt  = 1'b0;
          w_ferr_nxt  = 1'b0;
          w_bytes_nxt = '0;
          w_timer_nxt = '0;
          w_state_nxt = S_TX_START;
        end
      end
      S_TX_START: begin
        if (w_bit_end) begin
          w_timer_nxt = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_TX_DATA;
        end else begin
          w_timer_nxt = r_timer + T_ONE;
        end
      end
      S_TX_DATA: begin
        if (w_bit_end) begin
          w_timer_nxt = '0;
          if (r_bit == 3'd7) begin
            w_state_nxt = S_TX_STOP;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end else begin
          w_timer_nxt = r_timer + T_ONE;
        end
      end
      S_TX_STOP: begin
        if (w_bit_end) begin
          w_timer_nxt = '0;
          w_bytes_nxt = r_bytes + 7'd1;
          if (r_bytes == NBYTES - 7'd1) begin
            w_tmo_nxt    = '0;
            w_rx_cnt_nxt = '0;
            w_state_nxt  = S_RX_WAIT;
          end else begin
            w_hdr_nxt   = {r_hdr[631:0], 8'h00};
            w_state_nxt = S_TX_START;
          end
        end else begin
          w_timer_nxt = r_timer + T_ONE;
        end
      end
      S_RX_WAIT: begin
        if (w_rx_fall) begin
          w_timer_nxt = '0;
          w_state_nxt = S_RX_START;
        end else begin
          w_tmo_nxt = w_tmo_inc;
          if (w_tmo_inc == TMO_MAX) begin
            w_tout_nxt  = 1'b1;
            w_state_nxt = S_FINISH;
          end
        end
      end
      S_RX_START: begin
        // a start bit that is high again at mid-bit was a glitch
        if (w_half_end) begin
          w_timer_nxt = '0;
          w_bit_nxt   = '0;
          w_state_nxt = r_rx_sync ? S_RX_WAIT : S_RX_DATA;
        end else begin
          w_timer_nxt = r_timer + T_ONE;
        end
      end
      S_RX_DATA: begin
        if (w_bit_end) begin
          w_timer_nxt   = '0;
          w_rx_byte_nxt = {r_rx_sync, r_rx_byte[7:1]};
          if (r_bit == 3'd7) begin
            w_state_nxt = S_RX_STOP;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end else begin
          w_timer_nxt = r_timer + T_ONE;
        end
      end
      S_RX_STOP: begin
        if (w_bit_end) begin
          w_timer_nxt = '0;
          if (!r_rx_sync) begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = S_FINISH;
          end else begin
            w_nonce_nxt  = {r_nonce[23:0], r_rx_byte};
            w_rx_cnt_nxt = r_rx_cnt + 2'd1;
            w_tmo_nxt    = '0;
            w_state_nxt  = (r_rx_cnt == 2'd3) ? S_FINISH : S_RX_WAIT;
          end
        end else begin
          w_timer_nxt = r_timer + T_ONE;
        end
      end
      S_FINISH: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // txd is registered from the next-state view so the line never glitches
  always_comb begin
    w_txd_nxt = 1'b1;
    unique case (w_state_nxt)
      S_TX_START: w_txd_nxt = 1'b0;
      S_TX_DATA:  w_txd_nxt = w_tx_byte[w_bit_nxt];
      default:    w_txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_bit     <= '0;
      r_bytes   <= '0;
      r_tmo     <= '0;
      r_rx_byte <= '0;
      r_rx_cnt  <= '0;
      r_nonce   <= '0;
      r_tout    <= 1'b0;
      r_ferr    <= 1'b0;
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_bit     <= w_bit_nxt;
      r_bytes   <= w_bytes_nxt;
      r_tmo     <= w_tmo_nxt;
      r_rx_byte <= w_rx_byte_nxt;
      r_rx_cnt  <= w_rx_cnt_nxt;
      r_nonce   <= w_nonce_nxt;
      r_tout    <= w_tout_nxt;
      r_ferr    <= w_ferr_nxt;
      r_txd     <= w_txd_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_done    <= (w_state_nxt == S_FINISH);
    end
  end

  always_ff @(posedge clock) begin
    r_hdr <= w_hdr_nxt;
  end

endmodule

// File: tb/tb_header_uart_sender.sv
// tb_header_uart_sender: header framing model, nonce reply,
// timeout, glitch/framing error, busy rejection and reset.

module tb_header_uart_sender;

  localparam int C0   = 4;
  localparam int T0   = 100;
  localparam int C1   = 8;
  localparam int T1   = 1000;
  localparam int TXC0 = 800 * C0;
  // line change seen at next edge, two sync stages, one edge-detect
  // stage, then half a bit plus nine bits to the stop-bit centre
  localparam int LAT0 = 3 + C0 / 2 + 9 * C0;
  localparam int LAT1 = 3 + C1 / 2 + 9 * C1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         reset;
  logic         start0, start1;
  logic [639:0] hdr0, hdr1;
  logic         txd0, txd1;
  logic         rxd0, rxd1;
  logic         busy0, busy1;
  logic         done0, done1;
  logic         tout0, tout1;
  logic         ferr0, ferr1;
  logic [31:0]  nonce0, nonce1;
  logic [6:0]   bs0, bs1;

  header_uart_sender #(.CLKS_PER_BIT(C0), .TIMEOUT_CYCLES(T0)) u0 (
    .clock(clk), .reset(reset), .start(start0), .header(hdr0),
    .txd(txd0), .rxd(rxd0), .busy(busy0), .done(done0),
    .timed_out(tout0), .frame_err(ferr0), .nonce_out(nonce0),
    .bytes_sent(bs0)
  );

  header_uart_sender #(.CLKS_PER_BIT(C1), .TIMEOUT_CYCLES(T1)) u1 (
    .clock(clk), .reset(reset), .start(start1), .header(hdr1),
    .txd(txd1), .rxd(rxd1), .busy(busy1), .done(done1),
    .timed_out(tout1), .frame_err(ferr1), .nonce_out(nonce1),
    .bytes_sent(bs1)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // reference: 80 frames of {0, 8 data LSB first, 1}, C0 cycles each
  logic         m_on = 1'b0;
  int           m_t0 = 0;
  logic [639:0] m_hdr = '0;

  always @(negedge clk) begin
    int k, f, p;
    logic [7:0] b;
    logic e_txd;
    int e_bs;
    if (m_on) begin
      k = cyc - m_t0;
      if (k >= 0 && k <= TXC0) begin
        if (k == TXC0) begin
          e_txd = 1'b1;
          e_bs  = 80;
        end else begin
          f = k / C0;
          p = f % 10;
          b = 8'(m_hdr >> (632 - 8 * (f / 10)));
          e_txd = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : b[p-1];
          e_bs  = k / (10 * C0);
        end
        chk("txd", 64'(txd0), 64'(e_txd));
        chk("bytes_sent", 64'(bs0), 64'(e_bs));
        chk("busy_tx", 64'(busy0), 64'd1);
      end
    end
  end

  logic       dec_en = 1'b0;
  logic [7:0] dec_q[$];

  always begin
    logic [7:0] d;
    @(negedge clk);
    if (dec_en && txd0 == 1'b0) begin
      d = '0;
      repeat (C0 / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (C0) @(negedge clk);
        d[i] = txd0;
      end
      repeat (C0) @(negedge clk);
      dec_q.push_back(d);
    end
  end

  task automatic drive(input bit which, input logic v);
    if (which) rxd1 = v;
    else rxd0 = v;
  endtask

  task automatic send_byte(input bit which, input logic [7:0] b,
                           input logic stop_v, output int e0);
    int c;
    c  = which ? C1 : C0;
    e0 = cyc;
    drive(which, 1'b0);
    step(c);
    for (int i = 0; i < 8; i++) begin
      drive(which, b[i]);
      step(c);
    end
    drive(which, stop_v);
    step(c / 2 + 2);
    drive(which, 1'b1);
  endtask

  task automatic start_u0(input logic [639:0] h);
    hdr0   = h;
    start0 = 1'b1;
    step(1);
    start0 = 1'b0;
    m_hdr  = h;
    m_t0   = cyc;
    m_on   = 1'b1;
  endtask

  logic [639:0] ha, hb;
  int e0;

  initial begin
    reset  = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    hdr0   = '0;
    hdr1   = '0;
    rxd0   = 1'b1;
    rxd1   = 1'b1;
    ha = {32'h01000000, {24{24'h5a3c0f}}, 32'h42a14695};
    hb = ~ha;
    step(3);
    chk("rst_txd", 64'(txd0), 64'd1);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_done", 64'(done0), 64'd0);
    chk("rst_tout", 64'(tout0), 64'd0);
    chk("rst_ferr", 64'(ferr0), 64'd0);
    chk("rst_nonce", 64'(nonce0), 64'd0);
    chk("rst_bytes", 64'(bs0), 64'd0);
    reset = 1'b0;
    step(2);

    dec_en = 1'b1;
    start_u0(ha);
    step(500);
    hdr0   = hb;
    start0 = 1'b1;
    step(1);
    start0 = 1'b0;
    for (int t = 0; t < TXC0 && bs0 != 7'd80; t++) step(1);
    chk("tx_len", 64'(cyc - m_t0), 64'(TXC0));
    chk("tx_idle", 64'(txd0), 64'd1);
    step(C0);
    dec_en = 1'b0;
    m_on   = 1'b0;
    chk("dec_count", 64'(dec_q.size()), 64'd80);
    chk("dec_first", 64'(dec_q[0]), 64'h01);
    chk("dec_second", 64'(dec_q[1]), 64'h00);
    chk("dec_76", 64'(dec_q[76]), 64'h42);
    chk("dec_last", 64'(dec_q[79]), 64'h95);

    step(5);
    send_byte(1'b0, 8'h42, 1'b1, e0);
    step(2);
    send_byte(1'b0, 8'ha1, 1'b1, e0);
    step(2);
    send_byte(1'b0, 8'h46, 1'b1, e0);
    step(2);
    send_byte(1'b0, 8'h95, 1'b1, e0);
    chk("pre_done", 64'(done0), 64'd0);
    for (int t = 0; t < LAT0 && !done0; t++) step(1);
    chk("done_cycle", 64'(cyc), 64'(e0 + LAT0));
    chk("done_pulse", 64'(done0), 64'd1);
    chk("busy_at_done", 64'(busy0), 64'd1);
    chk("nonce", 64'(nonce0), 64'h42a14695);
    chk("ok_tout", 64'(tout0), 64'd0);
    chk("ok_ferr", 64'(ferr0), 64'd0);
    hdr0   = hb;
    start0 = 1'b1;
    step(1);
    start0 = 1'b0;
    chk("post_done", 64'(done0), 64'd0);
    chk("post_busy", 64'(busy0), 64'd0);
    chk("post_txd", 64'(txd0), 64'd1);
    chk("nonce_held", 64'(nonce0), 64'h42a14695);
    step(3);
    chk("still_idle", 64'(busy0), 64'd0);

    start_u0(ha);
    chk("nonce_clr", 64'(nonce0), 64'd0);
    for (int t = 0; t < TXC0 + 10 && bs0 != 7'd80; t++) step(1);
    step(2);
    m_on = 1'b0;
    send_byte(1'b0, 8'h11, 1'b1, e0);
    step(2);
    send_byte(1'b0, 8'h22, 1'b1, e0);
    for (int t = 0; t < LAT0 + T0 + 20 && !done0; t++) step(1);
    chk("tmo_cycle", 64'(cyc), 64'(e0 + LAT0 + T0));
    chk("tmo_flag", 64'(tout0), 64'd1);
    chk("tmo_ferr", 64'(ferr0), 64'd0);
    step(3);

    hdr1   = ha;
    start1 = 1'b1;
    step(1);
    start1 = 1'b0;
    for (int t = 0; t < 800 * C1 + 10 && bs1 != 7'd80; t++) step(1);
    chk("u1_tx_done", 64'(bs1), 64'd80);
    step(5);
    rxd1 = 1'b0;
    step(3);
    rxd1 = 1'b1;
    step(30);
    chk("glitch_busy", 64'(busy1), 64'd1);
    chk("glitch_done", 64'(done1), 64'd0);
    chk("glitch_ferr", 64'(ferr1), 64'd0);
    send_byte(1'b1, 8'ha5, 1'b0, e0);
    for (int t = 0; t < LAT1 && !done1; t++) step(1);
    chk("ferr_cycle", 64'(cyc), 64'(e0 + LAT1));
    chk("ferr_flag", 64'(ferr1), 64'd1);
    chk("ferr_tout", 64'(tout1), 64'd0);
    step(3);

    start_u0(ha);
    for (int t = 0; t < TXC0 && bs0 != 7'd37; t++) step(1);
    chk("reach_37", 64'(bs0), 64'd37);
    step(3 * C0 + 1);
    m_on  = 1'b0;
    reset = 1'b1;
    step(1);
    chk("mid_rst_txd", 64'(txd0), 64'd1);
    chk("mid_rst_busy", 64'(busy0), 64'd0);
    chk("mid_rst_bytes", 64'(bs0), 64'd0);
    chk("mid_rst_done", 64'(done0), 64'd0);
    step(1);
    reset = 1'b0;
    for (int t = 0; t < 100; t++) begin
      step(1);
      chk("quiet_txd", 64'(txd0), 64'd1);
      chk("quiet_busy", 64'(busy0), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
